// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue: circular buffer of single-instruction entries,
// two-wide enqueue and dequeue, flushed on kill. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH       = 8,
    parameter int ADDR_LEN    = 32,
    parameter int INSN_LEN    = 32,
    parameter int GSH_BHR_LEN = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       kill,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_LEN-1:0]        in_pc,
    input  logic [INSN_LEN-1:0]        in_inst1,
    input  logic [INSN_LEN-1:0]        in_inst2,
    input  logic                       in_invalid2,
    input  logic                       in_prcond,
    input  logic [ADDR_LEN-1:0]        in_npc,
    input  logic [GSH_BHR_LEN-1:0]     in_bhr,
    output logic                       out_valid1,
    output logic                       out_valid2,
    output logic [ADDR_LEN-1:0]        out_pc1,
    output logic [ADDR_LEN-1:0]        out_pc2,
    output logic [INSN_LEN-1:0]        out_inst1,
    output logic [INSN_LEN-1:0]        out_inst2,
    output logic                       out_prcond1,
    output logic                       out_prcond2,
    output logic [ADDR_LEN-1:0]        out_npc1,
    output logic [ADDR_LEN-1:0]        out_npc2,
    output logic [GSH_BHR_LEN-1:0]     out_bhr1,
    output logic [GSH_BHR_LEN-1:0]     out_bhr2,
    input  logic                       deq,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_LEN-1:0]    pc;
        logic [INSN_LEN-1:0]    inst;
        logic                   prcond;
        logic [ADDR_LEN-1:0]    npc;
        logic [GSH_BHR_LEN-1:0] bhr;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_accept;
    logic            w_write;
    logic            w_bypass;
    logic [1:0]      w_push;
    logic [1:0]      w_pop;
    logic [PW-1:0]   w_tail1;
    logic [PW-1:0]   w_head1;
    entry_t          w_ent1;
    entry_t          w_ent2;
    entry_t          w_out1;
    entry_t          w_out2;
    logic            w_v1;
    logic            w_v2;

    assign in_ready = (r_count <= CW'(DEPTH - 2));
    assign count    = r_count;
    assign w_accept = in_valid & in_ready & ~kill;
    assign w_tail1  = r_tail + PW'(1);
    assign w_head1  = r_head + PW'(1);

    assign w_ent1 = '{pc: in_pc, inst: in_inst1, prcond: in_prcond, npc: in_npc, bhr: in_bhr};
    assign w_ent2 = '{pc: in_pc + ADDR_LEN'(4), inst: in_inst2, prcond: in_prcond,
                      npc: in_npc, bhr: in_bhr};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_accept & (r_count == CW'(0));
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed group consumed by decode in the same cycle is never stored.
    assign w_write = w_accept & ~(w_bypass & deq);

    // Push and pop amounts for this cycle.
    always_comb begin
        w_push = 2'd0;
        w_pop  = 2'd0;
        if (w_write) begin
            w_push = in_invalid2 ? 2'd1 : 2'd2;
        end else begin
            w_push = 2'd0;
        end
        if (deq && !kill) begin
            w_pop = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
        end else begin
            w_pop = 2'd0;
        end
    end

    // Pointer and occupancy registers; kill and reset both flush.
    always_ff @(posedge clk) begin
        if (reset || kill) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_push);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage; contents survive a flush.
    always_ff @(posedge clk) begin
        if (w_write && !reset) begin
            r_mem[r_tail] <= w_ent1;
            if (!in_invalid2) begin
                r_mem[w_tail1] <= w_ent2;
            end
        end
    end

    // Output slot selection with zeroed fields for invalid slots.
    always_comb begin
        w_v1   = 1'b0;
        w_v2   = 1'b0;
        w_out1 = '0;
        w_out2 = '0;
        if (w_bypass) begin
            w_v1   = 1'b1;
            w_v2   = ~in_invalid2;
            w_out1 = w_ent1;
            w_out2 = in_invalid2 ? entry_t'('0) : w_ent2;
        end else begin
            w_v1   = (r_count >= CW'(1));
            w_v2   = (r_count >= CW'(2));
            w_out1 = w_v1 ? r_mem[r_head]  : entry_t'('0);
            w_out2 = w_v2 ? r_mem[w_head1] : entry_t'('0);
        end
    end

    assign out_valid1  = w_v1;
    assign out_valid2  = w_v2;
    assign out_pc1     = w_out1.pc;
    assign out_pc2     = w_out2.pc;
    assign out_inst1   = w_out1.inst;
    assign out_inst2   = w_out2.inst;
    assign out_prcond1 = w_out1.prcond;
    assign out_prcond2 = w_out2.prcond;
    assign out_npc1    = w_out1.npc;
    assign out_npc2    = w_out2.npc;
    assign out_bhr1    = w_out1.bhr;
    assign out_bhr2    = w_out2.bhr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=8); bypass checks under FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        kill;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst1;
    logic [31:0] in_inst2;
    logic        in_invalid2;
    logic        in_prcond;
    logic [31:0] in_npc;
    logic [9:0]  in_bhr;
    logic        out_valid1;
    logic        out_valid2;
    logic [31:0] out_pc1;
    logic [31:0] out_pc2;
    logic [31:0] out_inst1;
    logic [31:0] out_inst2;
    logic        out_prcond1;
    logic        out_prcond2;
    logic [31:0] out_npc1;
    logic [31:0] out_npc2;
    logic [9:0]  out_bhr1;
    logic [9:0]  out_bhr2;
    logic        deq;
    logic [3:0]  count;

    int n_total = 0;
    int n_pass  = 0;

    fetch_queue #(.DEPTH(8), .ADDR_LEN(32), .INSN_LEN(32), .GSH_BHR_LEN(10)) dut (
        .clk(clk), .reset(reset), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst1(in_inst1), .in_inst2(in_inst2), .in_invalid2(in_invalid2),
        .in_prcond(in_prcond), .in_npc(in_npc), .in_bhr(in_bhr),
        .out_valid1(out_valid1), .out_valid2(out_valid2), .out_pc1(out_pc1), .out_pc2(out_pc2),
        .out_inst1(out_inst1), .out_inst2(out_inst2), .out_prcond1(out_prcond1),
        .out_prcond2(out_prcond2), .out_npc1(out_npc1), .out_npc2(out_npc2),
        .out_bhr1(out_bhr1), .out_bhr2(out_bhr2), .deq(deq), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        deq      = 1'b0;
        kill     = 1'b0;
    endtask

    // Advance one edge, then drop the handshake inputs so outputs reflect stored state.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic inv2, input logic d);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_inst1    = 32'hA000_0000 | pc;
        in_inst2    = 32'hB000_0000 | pc;
        in_invalid2 = inv2;
        in_prcond   = pc[3];
        in_npc      = pc + 32'h0000_0040;
        in_bhr      = pc[9:0] ^ 10'h155;
        deq         = d;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        in_pc = 32'h0; in_inst1 = 32'h0; in_inst2 = 32'h0; in_invalid2 = 1'b0;
        in_prcond = 1'b0; in_npc = 32'h0; in_bhr = 10'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_ready", 64'(in_ready), 64'd1);
        check_eq("rst_v1", 64'(out_valid1), 64'd0);
        check_eq("rst_v2", 64'(out_valid2), 64'd0);
        check_eq("rst_pc1", 64'(out_pc1), 64'd0);
        check_eq("rst_inst2", 64'(out_inst2), 64'd0);
        check_eq("rst_npc1", 64'(out_npc1), 64'd0);
        check_eq("rst_bhr2", 64'(out_bhr2), 64'd0);

        // Fill with four full groups.
        drive(32'h100, 1'b0, 1'b0); tick();
        check_eq("fill_cnt2", 64'(count), 64'd2);
        check_eq("fill_rdy2", 64'(in_ready), 64'd1);
        drive(32'h108, 1'b0, 1'b0); tick();
        check_eq("fill_cnt4", 64'(count), 64'd4);
        drive(32'h110, 1'b0, 1'b0); tick();
        check_eq("fill_cnt6", 64'(count), 64'd6);
        check_eq("fill_rdy6", 64'(in_ready), 64'd1);
        drive(32'h118, 1'b0, 1'b0); tick();
        check_eq("fill_cnt8", 64'(count), 64'd8);
        check_eq("fill_rdy8", 64'(in_ready), 64'd0);
        check_eq("fill_pc1", 64'(out_pc1), 64'h100);
        check_eq("fill_pc2", 64'(out_pc2), 64'h104);
        check_eq("fill_inst1", 64'(out_inst1), 64'hA000_0100);
        check_eq("fill_inst2", 64'(out_inst2), 64'hB000_0100);
        check_eq("fill_npc2", 64'(out_npc2), 64'h140);
        check_eq("fill_bhr2", 64'(out_bhr2), 64'h055);
        check_eq("fill_prc1", 64'(out_prcond1), 64'd0);
        drive(32'h120, 1'b0, 1'b0); tick();
        check_eq("full_hold", 64'(count), 64'd8);

        // Flush, then single-instruction group.
        kill = 1'b1; tick();
        check_eq("kill_cnt", 64'(count), 64'd0);
        check_eq("kill_rdy", 64'(in_ready), 64'd1);
        drive(32'h208, 1'b1, 1'b0); tick();
        check_eq("inv2_cnt", 64'(count), 64'd1);
        check_eq("inv2_v1", 64'(out_valid1), 64'd1);
        check_eq("inv2_pc1", 64'(out_pc1), 64'h208);
        check_eq("inv2_prc1", 64'(out_prcond1), 64'd1);
        check_eq("inv2_npc1", 64'(out_npc1), 64'h248);
        check_eq("inv2_v2", 64'(out_valid2), 64'd0);
        check_eq("inv2_pc2", 64'(out_pc2), 64'd0);
        check_eq("inv2_inst2", 64'(out_inst2), 64'd0);

        // Streaming across several pointer wraps.
        kill = 1'b1; tick();
        for (int i = 0; i < 20; i++) begin
            drive(32'h400 + 32'(8 * i), 1'b0, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
            #1;
            check_eq("wrap_byp_pc1", 64'(out_pc1), 64'(32'h400 + 32'(8 * i)));
            check_eq("wrap_byp_pc2", 64'(out_pc2), 64'(32'h404 + 32'(8 * i)));
            tick();
            check_eq("wrap_cnt", 64'(count), 64'd0);
`else
            tick();
            check_eq("wrap_cnt", 64'(count), 64'd2);
            check_eq("wrap_pc1", 64'(out_pc1), 64'(32'h400 + 32'(8 * i)));
            check_eq("wrap_pc2", 64'(out_pc2), 64'(32'h404 + 32'(8 * i)));
`endif
        end

        // Simultaneous push/pop at count 6, then count 7 and deq-only.
        kill = 1'b1; tick();
        drive(32'h300, 1'b0, 1'b0); tick();
        drive(32'h308, 1'b0, 1'b0); tick();
        drive(32'h310, 1'b0, 1'b0); tick();
        check_eq("c6_cnt", 64'(count), 64'd6);
        drive(32'h318, 1'b0, 1'b1); tick();
        check_eq("c6_pushpop", 64'(count), 64'd6);
        check_eq("c6_pc1", 64'(out_pc1), 64'h308);
        drive(32'h320, 1'b1, 1'b0); tick();
        check_eq("c7_cnt", 64'(count), 64'd7);
        check_eq("c7_rdy", 64'(in_ready), 64'd0);
        deq = 1'b1; tick();
        check_eq("c5_cnt", 64'(count), 64'd5);
        check_eq("c5_pc1", 64'(out_pc1), 64'h310);
        check_eq("c5_rdy", 64'(in_ready), 64'd1);

        // Kill has priority over push and pop.
        drive(32'h340, 1'b0, 1'b1);
        kill = 1'b1; tick();
        check_eq("kpri_cnt", 64'(count), 64'd0);
        check_eq("kpri_v1", 64'(out_valid1), 64'd0);
        check_eq("kpri_v2", 64'(out_valid2), 64'd0);
        check_eq("kpri_rdy", 64'(in_ready), 64'd1);

        // Reset mid-operation discards the concurrent push.
        drive(32'h500, 1'b0, 1'b0); tick();
        check_eq("rmid_pre", 64'(count), 64'd2);
        drive(32'h508, 1'b0, 1'b1);
        reset = 1'b1; tick();
        reset = 1'b0;
        check_eq("rmid_cnt", 64'(count), 64'd0);
        check_eq("rmid_v1", 64'(out_valid1), 64'd0);

        // Push into an empty queue with deq high in the same cycle.
        drive(32'h600, 1'b0, 1'b1);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check_eq("byp_v1", 64'(out_valid1), 64'd1);
        check_eq("byp_v2", 64'(out_valid2), 64'd1);
        check_eq("byp_pc2", 64'(out_pc2), 64'h604);
        check_eq("byp_inst1", 64'(out_inst1), 64'hA000_0600);
        tick();
        check_eq("byp_cnt", 64'(count), 64'd0);
        drive(32'h610, 1'b1, 1'b0);
        #1;
        check_eq("byp_inv2_v2", 64'(out_valid2), 64'd0);
        tick();
        check_eq("byp_store_cnt", 64'(count), 64'd1);
        check_eq("byp_store_pc1", 64'(out_pc1), 64'h610);
`else
        check_eq("nob_v1", 64'(out_valid1), 64'd0);
        tick();
        check_eq("nob_cnt", 64'(count), 64'd2);
        check_eq("nob_pc1", 64'(out_pc1), 64'h600);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
